sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO buffer with valid/ready handshake on both sides.
//  Generalises the team's 16x8 transfer buffer: configurable width/depth, correct full/empty
//  at every depth, occupancy count, almost-flags, sticky overflow and synchronous flush.
//  Sits between a producer and consumer sharing clk; two read modes selected by FWFT.
// PARAMETERS
//  DATA_W    16        data word width
//  DEPTH     8         number of entries; power of 2, >= 2; AW = $clog2(DEPTH)
//  AF_LEVEL  DEPTH-1   almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL  1         almost_empty asserts when count <= AE_LEVEL
//  FWFT      1         1 = first-word-fall-through (show-ahead); 0 = registered pop
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  flush         in   1       synchronous clear of contents
//  wr_valid      in   1       producer has wr_data
//  wr_data       in   DATA_W  write word
//  wr_ready      out  1       FIFO can accept a word (= !full)
//  rd_valid      out  1       rd_data holds a valid word
//  rd_data       out  DATA_W  read word
//  rd_ready      in   1       consumer takes/requests a word
//  count         out  AW+1    current occupancy, 0..DEPTH
//  empty, full   out  1       count==0 / count==DEPTH
//  almost_empty  out  1       count <= AE_LEVEL
//  almost_full   out  1       count >= AF_LEVEL
//  overflow      out  1       sticky: write attempted while full
//  clr_err       in   1       clears overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, wr_ready=1,
//    rd_valid=0 (FWFT=0), rd_data=0 (FWFT=0), almost_empty=1, almost_full=0, overflow=0.
//    Storage array is not reset. Reset mid-transfer discards all contents.
//  - Pointers are AW+1 bits; address = low AW bits, wrap is implicit at DEPTH.
//    empty: ptrs equal; full: addresses equal and MSBs differ. count = wr_ptr - rd_ptr.
//  - Push: wr_valid && wr_ready -> mem[wr_addr] <= wr_data, wr_ptr++ at the edge.
//  - wr_valid && full: word dropped, pointers unchanged, overflow <= 1 next cycle.
//  - FWFT=1: rd_valid = !empty, rd_data = mem[rd_addr] (combinational read).
//    Pop on rd_valid && rd_ready. Latency: written word visible on rd_data 1 cycle after push.
//  - FWFT=0: pop when rd_ready && !empty; rd_data <= mem[rd_addr] and rd_valid = 1 for
//    exactly the following cycle; rd_ready while empty has no effect (rd_valid=0 next).
//  - Simultaneous push+pop: count unchanged; allowed at any level except push is refused
//    when full (no pass-through) and pop impossible when empty (write still accepted).
//  - flush=1: pointers -> 0, FWFT=0 rd_valid -> 0; flush overrides push/pop in the
//    same cycle (those words lost). overflow unaffected by flush.
//  - clr_err clears overflow; a new overflow event in the same cycle wins (stays 1).
//  - All status outputs derive from registered pointers; no comb path from wr_valid/rd_ready
//    to wr_ready/rd_valid.
// STRUCTURE
//  - Package fifo_pkg: localparam helpers (clog2-based AW), mode constants
//    FIFO_MODE_FWFT=1 / FIFO_MODE_STD=0.
//  - Sub-module fifo_mem: DEPTH x DATA_W storage, one sync write port, one async read port.
//    Pointer/flag/handshake logic stays in sync_fifo_param.
// TESTING
//  1 Reset then idle: empty=1, wr_ready=1, count=0, rd_valid=0, overflow=0.
//  2 DEPTH=8, push 0x0001..0x0008 -> full=1, count=8, wr_ready=0; 9th push 0xDEAD -> dropped,
//    overflow=1; pop all -> 0x0001..0x0008 in order, empty=1; clr_err -> overflow=0.
//  3 Wrap: push 5, pop 5, push 8, pop 8 -> data in order, full at count 8, pointers wrap.
//  4 Full with push+pop same cycle -> pop accepted, push refused, count=7.
//    Empty with push+pop -> push accepted, count=1.
//  5 FWFT=0: push 0x00AA, rd_ready 1 cycle -> rd_data=0x00AA, rd_valid=1 next cycle only.
//  6 Flush with count=4 and concurrent push -> count=0, empty=1;
//    rst_n low mid-burst -> reset values immediately, no clk edge needed.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared mode constants and address-width helper for the FIFO slice
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int AW = fifo_aw(DEPTH);

    logic              flush;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              clr_err;

    modport master (
        output flush, wr_valid, wr_data, rd_ready, clr_err,
        input  wr_ready, rd_valid, rd_data, count, empty, full,
               almost_empty, almost_full, overflow
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready, clr_err,
        output wr_ready, rd_valid, rd_data, count, empty, full,
               almost_empty, almost_full, overflow
    );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = fifo_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are deliberately not reset; pointers alone define validity.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with show-ahead or registered-pop read side
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FIFO_MODE_FWFT
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_param_if.slave  bus
);

    localparam int          AW   = fifo_aw(DEPTH);
    localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_overflow;
    logic [AW:0]       w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_mem_rdata;

    // Extra pointer MSB separates full from empty when the addresses coincide.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Flags are registered-pointer based, so a full FIFO never passes a word through.
    assign w_push = bus.wr_valid && !w_full && !bus.flush;
    assign w_pop  = bus.rd_ready && !w_empty && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A fresh overflow event takes priority over clearing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign bus.rd_valid = !w_empty;
            assign bus.rd_data  = w_mem_rdata;
        end else begin : g_std
            logic              r_rd_valid;
            logic [DATA_W-1:0] r_rd_data;

            // Popped word is presented for exactly one cycle after the request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_rd_valid <= w_pop;
                    if (w_pop) begin
                        r_rd_data <= w_mem_rdata;
                    end
                end
            end

            assign bus.rd_valid = r_rd_valid;
            assign bus.rd_data  = r_rd_data;
        end
    endgenerate

    assign bus.wr_ready     = !w_full;
    assign bus.count        = w_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = (w_count <= AE_L);
    assign bus.almost_full  = (w_count >= AF_L);
    assign bus.overflow     = r_overflow;

endmodule
